// File: rtl/key_recorder.sv
// key_recorder: samples four keys per tick while recording, stores run-length encoded
// entries {keys, dur} in RAM and replays them. Define KEY_RECORDER_LOOP_EN for looped playback.
module key_recorder #(
  parameter int TICK_DIV = 500000,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        keys,
  input  logic              record_btn,
  input  logic              play_btn,
  output logic [1:0]        mode,
  output logic [3:0]        playback_keys,
  output logic              full,
  output logic [ADDR_W:0]   length
);

  localparam int                CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [11:0]       DUR_MAX   = 12'd4095;
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LEN_ZERO  = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W:0]   LEN_FULL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO  = ADDR_W'(0);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RECORD     = 3'd1,
    S_PLAY_FETCH = 3'd2,
    S_PLAY_LOAD  = 3'd3,
    S_PLAY_RUN   = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  tick_cnt_r, tick_cnt_s;
  logic [3:0]        run_keys_r, run_keys_s;
  logic [11:0]       run_len_r, run_len_s;
  logic [11:0]       remaining_r, remaining_s;
  logic [ADDR_W-1:0] rd_ptr_r, rd_ptr_s;
  logic [ADDR_W:0]   length_r, length_s;
  logic              full_r, full_s;
  logic [3:0]        playback_keys_r, playback_keys_s;
  logic [1:0]        mode_r, mode_s;
  logic              tick_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [15:0]       mem_wdata_s;
  logic [15:0]       mem_r [DEPTH];
  logic [15:0]       rd_data_r;

  assign mode          = mode_r;
  assign playback_keys = playback_keys_r;
  assign full          = full_r;
  assign length        = length_r;

  // Next-state, datapath and RAM port control
  always_comb begin
    state_s         = state_r;
    run_keys_s      = run_keys_r;
    run_len_s       = run_len_r;
    remaining_s     = remaining_r;
    rd_ptr_s        = rd_ptr_r;
    length_s        = length_r;
    full_s          = full_r;
    playback_keys_s = playback_keys_r;
    tick_cnt_s      = CNT_ZERO;
    mem_we_s        = 1'b0;
    mem_wdata_s     = {run_keys_r, run_len_r};
    tick_s          = ((state_r == S_RECORD) || (state_r == S_PLAY_RUN)) &&
                      (tick_cnt_r == TICK_LAST);
    if (state_r == S_RECORD) begin
      mem_addr_s = length_r[ADDR_W-1:0];
    end else begin
      mem_addr_s = rd_ptr_r;
    end

    case (state_r)
      S_IDLE: begin
        if (record_btn) begin
          state_s    = S_RECORD;
          length_s   = LEN_ZERO;
          full_s     = 1'b0;
          run_keys_s = keys;
          run_len_s  = 12'd1;
        end else if (play_btn && (length_r != LEN_ZERO)) begin
          state_s  = S_PLAY_FETCH;
          rd_ptr_s = PTR_ZERO;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RECORD: begin
        // The stop pulse wins over a coinciding tick; that tick is dropped.
        if (record_btn) begin
          mem_we_s = 1'b1;
          length_s = length_r + LEN_ONE;
          state_s  = S_IDLE;
        end else if (tick_s) begin
          if ((keys == run_keys_r) && (run_len_r != DUR_MAX)) begin
            run_len_s = run_len_r + 12'd1;
          end else begin
            mem_we_s   = 1'b1;
            length_s   = length_r + LEN_ONE;
            run_keys_s = keys;
            run_len_s  = 12'd1;
            if ((length_r + LEN_ONE) == LEN_FULL) begin
              full_s  = 1'b1;
              state_s = S_IDLE;
            end else begin
              state_s = S_RECORD;
            end
          end
        end else begin
          state_s = S_RECORD;
        end
      end
      S_PLAY_FETCH: begin
        if (play_btn) begin
          playback_keys_s = 4'h0;
          state_s         = S_IDLE;
        end else begin
          state_s = S_PLAY_LOAD;
        end
      end
      S_PLAY_LOAD: begin
        if (play_btn) begin
          playback_keys_s = 4'h0;
          state_s         = S_IDLE;
        end else begin
          playback_keys_s = rd_data_r[15:12];
          remaining_s     = rd_data_r[11:0];
          state_s         = S_PLAY_RUN;
        end
      end
      S_PLAY_RUN: begin
        if (play_btn) begin
          playback_keys_s = 4'h0;
          state_s         = S_IDLE;
        end else if (tick_s) begin
          if (remaining_r > 12'd1) begin
            remaining_s = remaining_r - 12'd1;
          end else if ({1'b0, rd_ptr_r} == (length_r - LEN_ONE)) begin
`ifdef KEY_RECORDER_LOOP_EN
            rd_ptr_s = PTR_ZERO;
            state_s  = S_PLAY_FETCH;
`else
            playback_keys_s = 4'h0;
            state_s         = S_IDLE;
`endif
          end else begin
            rd_ptr_s = rd_ptr_r + PTR_ONE;
            state_s  = S_PLAY_FETCH;
          end
        end else begin
          state_s = S_PLAY_RUN;
        end
      end
      default: begin
        playback_keys_s = 4'h0;
        state_s         = S_IDLE;
      end
    endcase

    // The tick counter only runs while staying in a timed state; any entry starts it at zero.
    if (((state_s == S_RECORD) || (state_s == S_PLAY_RUN)) && (state_s == state_r)) begin
      if (tick_s) begin
        tick_cnt_s = CNT_ZERO;
      end else begin
        tick_cnt_s = tick_cnt_r + CNT_ONE;
      end
    end else begin
      tick_cnt_s = CNT_ZERO;
    end
  end

  // Mode encoding derived from the next state so mode tracks the state register
  always_comb begin
    mode_s = 2'b00;
    case (state_s)
      S_RECORD:                             mode_s = 2'b01;
      S_PLAY_FETCH, S_PLAY_LOAD, S_PLAY_RUN: mode_s = 2'b10;
      default:                              mode_s = 2'b00;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= S_IDLE;
      tick_cnt_r      <= CNT_ZERO;
      run_keys_r      <= 4'h0;
      run_len_r       <= 12'd0;
      remaining_r     <= 12'd0;
      rd_ptr_r        <= PTR_ZERO;
      length_r        <= LEN_ZERO;
      full_r          <= 1'b0;
      playback_keys_r <= 4'h0;
      mode_r          <= 2'b00;
    end else begin
      state_r         <= state_s;
      tick_cnt_r      <= tick_cnt_s;
      run_keys_r      <= run_keys_s;
      run_len_r       <= run_len_s;
      remaining_r     <= remaining_s;
      rd_ptr_r        <= rd_ptr_s;
      length_r        <= length_s;
      full_r          <= full_s;
      playback_keys_r <= playback_keys_s;
      mode_r          <= mode_s;
    end
  end

  // Single-port RAM with one-cycle read latency; contents survive reset
  always_ff @(posedge clock) begin
    if (mem_we_s && !reset) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
    rd_data_r <= mem_r[mem_addr_s];
  end

endmodule

// File: tb/tb_key_recorder.sv
// Directed self-checking bench for key_recorder with TICK_DIV=4, DEPTH=4.
module tb_key_recorder;
  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        keys = 4'h0;
  logic              record_btn = 1'b0;
  logic              play_btn = 1'b0;
  logic [1:0]        mode;
  logic [3:0]        playback_keys;
  logic              full;
  logic [ADDR_W:0]   length;
  int checks = 0;
  int passes = 0;

  key_recorder #(.TICK_DIV(TICK_DIV), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .keys(keys), .record_btn(record_btn),
    .play_btn(play_btn), .mode(mode), .playback_keys(playback_keys),
    .full(full), .length(length)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_record();
    record_btn = 1'b1; step(1); record_btn = 1'b0;
  endtask

  task automatic pulse_play();
    play_btn = 1'b1; step(1); play_btn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(2); reset = 1'b0;
    checks++; if (mode !== 2'b00) $display("FAIL reset_mode: got %b want 00", mode); else passes++;
    checks++; if (playback_keys !== 4'h0) $display("FAIL reset_pb: got %h want 0", playback_keys); else passes++;
    checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else passes++;
    checks++; if (length !== 3'd0) $display("FAIL reset_len: got %0d want 0", length); else passes++;
  endtask

  task automatic test_reset_mid_record();
    keys = 4'h1; pulse_record();
    checks++; if (mode !== 2'b01) $display("FAIL midrec_mode: got %b want 01", mode); else passes++;
    keys = 4'h2; step(4);
    checks++; if (length !== 3'd1) $display("FAIL midrec_len: got %0d want 1", length); else passes++;
    reset = 1'b1; step(1); reset = 1'b0;
    checks++; if (mode !== 2'b00) $display("FAIL midrec_rst_mode: got %b want 00", mode); else passes++;
    checks++; if (length !== 3'd0) $display("FAIL midrec_rst_len: got %0d want 0", length); else passes++;
    checks++; if (playback_keys !== 4'h0) $display("FAIL midrec_rst_pb: got %h want 0", playback_keys); else passes++;
    checks++; if (full !== 1'b0) $display("FAIL midrec_rst_full: got %b want 0", full); else passes++;
  endtask

  task automatic test_play_empty();
    pulse_play();
    checks++; if (mode !== 2'b00) $display("FAIL empty_mode: got %b want 00", mode); else passes++;
    step(2);
    checks++; if (mode !== 2'b00) $display("FAIL empty_mode_later: got %b want 00", mode); else passes++;
  endtask

  task automatic test_record_basic();
    keys = 4'h1; pulse_record();
    checks++; if (mode !== 2'b01) $display("FAIL rec_mode: got %b want 01", mode); else passes++;
    pulse_play();
    checks++; if (mode !== 2'b01) $display("FAIL rec_play_ignored: got %b want 01", mode); else passes++;
    step(7);
    keys = 4'h4; step(8);
    checks++; if (length !== 3'd1) $display("FAIL rec_len_mid: got %0d want 1", length); else passes++;
    pulse_record();
    checks++; if (mode !== 2'b00) $display("FAIL rec_stop_mode: got %b want 00", mode); else passes++;
    checks++; if (length !== 3'd2) $display("FAIL rec_len: got %0d want 2", length); else passes++;
    checks++; if (dut.mem_r[0] !== 16'h1003) $display("FAIL rec_mem0: got %h want 1003", dut.mem_r[0]); else passes++;
    checks++; if (dut.mem_r[1] !== 16'h4002) $display("FAIL rec_mem1: got %h want 4002", dut.mem_r[1]); else passes++;
    checks++; if (full !== 1'b0) $display("FAIL rec_full: got %b want 0", full); else passes++;
  endtask

  task automatic test_playback();
    logic [3:0] exp_keys;
    logic [1:0] exp_mode;
    keys = 4'h0; pulse_play();
    checks++; if (mode !== 2'b10) $display("FAIL play_fetch_mode: got %b want 10", mode); else passes++;
    checks++; if (playback_keys !== 4'h0) $display("FAIL play_fetch_pb: got %h want 0", playback_keys); else passes++;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      exp_mode = 2'b10;
      if (i < 2) exp_keys = 4'h0;
      else if (i < 16) exp_keys = 4'h1;
      else if (i < 24) exp_keys = 4'h4;
`ifdef KEY_RECORDER_LOOP_EN
      else if (i < 26) exp_keys = 4'h4;
      else exp_keys = 4'h1;
`else
      else begin exp_keys = 4'h0; exp_mode = 2'b00; end
`endif
      checks++; if (playback_keys !== exp_keys) $display("FAIL play_keys[%0d]: got %h want %h", i, playback_keys, exp_keys); else passes++;
      checks++; if (mode !== exp_mode) $display("FAIL play_mode[%0d]: got %b want %b", i, mode, exp_mode); else passes++;
    end
`ifdef KEY_RECORDER_LOOP_EN
    pulse_play();
    checks++; if (mode !== 2'b00) $display("FAIL loop_stop_mode: got %b want 00", mode); else passes++;
`endif
    checks++; if (length !== 3'd2) $display("FAIL play_len_kept: got %0d want 2", length); else passes++;
  endtask

  task automatic test_play_abort();
    pulse_play(); step(4);
    checks++; if (playback_keys !== 4'h1) $display("FAIL abort_run_pb: got %h want 1", playback_keys); else passes++;
    pulse_record();
    checks++; if (mode !== 2'b10) $display("FAIL abort_rec_ignored: got %b want 10", mode); else passes++;
    pulse_play();
    checks++; if (playback_keys !== 4'h0) $display("FAIL abort_pb: got %h want 0", playback_keys); else passes++;
    checks++; if (mode !== 2'b00) $display("FAIL abort_mode: got %b want 00", mode); else passes++;
  endtask

  task automatic test_full();
    keys = 4'h1; pulse_record();
    checks++; if (length !== 3'd0) $display("FAIL full_start_len: got %0d want 0", length); else passes++;
    keys = 4'h2; step(4);
    keys = 4'h3; step(4);
    keys = 4'h4; step(4);
    checks++; if (length !== 3'd3) $display("FAIL full_len3: got %0d want 3", length); else passes++;
    checks++; if (mode !== 2'b01) $display("FAIL full_mode3: got %b want 01", mode); else passes++;
    keys = 4'h5; step(4);
    checks++; if (full !== 1'b1) $display("FAIL full_flag: got %b want 1", full); else passes++;
    checks++; if (length !== 3'd4) $display("FAIL full_len: got %0d want 4", length); else passes++;
    checks++; if (mode !== 2'b00) $display("FAIL full_mode: got %b want 00", mode); else passes++;
    checks++; if (dut.mem_r[3] !== 16'h4001) $display("FAIL full_mem3: got %h want 4001", dut.mem_r[3]); else passes++;
    step(4);
    checks++; if (length !== 3'd4) $display("FAIL full_len_hold: got %0d want 4", length); else passes++;
    pulse_record();
    checks++; if (full !== 1'b0) $display("FAIL full_clear: got %b want 0", full); else passes++;
    checks++; if (length !== 3'd0) $display("FAIL full_restart_len: got %0d want 0", length); else passes++;
    pulse_record();
    checks++; if (length !== 3'd1) $display("FAIL full_short_len: got %0d want 1", length); else passes++;
    checks++; if (dut.mem_r[0] !== 16'h5001) $display("FAIL full_short_mem: got %h want 5001", dut.mem_r[0]); else passes++;
  endtask

  task automatic test_long_run();
    keys = 4'h8; pulse_record();
    step(16380);
    checks++; if (length !== 3'd1) $display("FAIL long_len1: got %0d want 1", length); else passes++;
    checks++; if (mode !== 2'b01) $display("FAIL long_mode: got %b want 01", mode); else passes++;
    pulse_record();
    checks++; if (length !== 3'd2) $display("FAIL long_len2: got %0d want 2", length); else passes++;
    checks++; if (dut.mem_r[0] !== 16'h8FFF) $display("FAIL long_mem0: got %h want 8fff", dut.mem_r[0]); else passes++;
    checks++; if (dut.mem_r[1] !== 16'h8001) $display("FAIL long_mem1: got %h want 8001", dut.mem_r[1]); else passes++;
    pulse_play(); step(2);
    checks++; if (playback_keys !== 4'h8) $display("FAIL long_play_pb: got %h want 8", playback_keys); else passes++;
    pulse_play();
    checks++; if (mode !== 2'b00) $display("FAIL long_abort_mode: got %b want 00", mode); else passes++;
  endtask

  task automatic test_back_to_back();
    keys = 4'h8;
    record_btn = 1'b1; play_btn = 1'b1; step(1); record_btn = 1'b0; play_btn = 1'b0;
    checks++; if (mode !== 2'b01) $display("FAIL both_mode: got %b want 01", mode); else passes++;
    step(3);
    pulse_record();
    checks++; if (length !== 3'd1) $display("FAIL stop_tick_len: got %0d want 1", length); else passes++;
    checks++; if (dut.mem_r[0] !== 16'h8001) $display("FAIL stop_tick_mem: got %h want 8001", dut.mem_r[0]); else passes++;
    checks++; if (mode !== 2'b00) $display("FAIL stop_tick_mode: got %b want 00", mode); else passes++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_record();
    test_play_empty();
    test_record_basic();
    test_playback();
    test_play_abort();
    test_full();
    test_long_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
